spi_host_engine: RTL and testbench
==================================

// Module: spi_host_engine
// PURPOSE
//  SPI host-side transfer engine: drives chip-select and serial data toward the PWM
//  peripheral's SPI bridge and captures its returned byte stream. Sits between the
//  register-access sequencer and the SPI pins. Clocked directly by the serial clock.
//  Data to peripheral: posedge launch. Data from peripheral: negedge capture.
// PARAMETERS
//  MAX_BYTES  4  maximum bytes per cs_n frame (cmd_len range 0..MAX_BYTES-1)
//  RX_SKEW    1  leading captured bits discarded; peripheral output lags by one sclk
//  CS_GAP     2  sclk cycles cs_n held high between frames (>=1)
// PORTS
//  sclk       in   1            serial clock; all state runs on it
//  rst_n      in   1            asynchronous, active-low reset
//  cmd_valid  in   1            frame request
//  cmd_ready  out  1            engine idle, request accepted when valid&ready
//  cmd_len    in   clog2(MAX_BYTES)  bytes in frame minus 1
//  tx_data    in   8*MAX_BYTES  frame payload; byte0 = [7:0], sent first, MSB first
//  rx_data    out  8*MAX_BYTES  returned payload, same byte/bit order; unused bytes 0
//  done       out  1            one-cycle pulse, rx_data valid from the same posedge
//  busy       out  1            high from accept until GAP expiry
//  spi_cs_n   out  1            chip select to peripheral cs_n, active low
//  spi_miso   out  1            serial data to peripheral miso pin
//  spi_mosi   in   1            serial data from peripheral mosi pin
// BEHAVIOUR
//  Reset (async): state=IDLE, cmd_ready=1, busy=0, done=0, spi_cs_n=1, spi_miso=0,
//   rx_data=0, counters=0. Reset mid-frame aborts immediately; no done pulse.
//  N = 8*(cmd_len+1) data bits; frame spans N+RX_SKEW sclk cycles with cs_n low.
//  IDLE: cmd_ready=1. Posedge with cmd_valid: latch tx_data/cmd_len, clear rx shadow,
//   spi_cs_n<=0, spi_miso<=bit7 of byte0, bit_cnt<=0, cmd_ready<=0, busy<=1 -> SHIFT.
//  SHIFT (posedge): bit_cnt++; while bit_cnt<N launch next bit, else spi_miso<=0.
//   On bit_cnt==N+RX_SKEW-1: spi_cs_n<=1, rx_data<=shadow, done<=1 -> GAP.
//  Capture (negedge, cs_n low): cap_cnt++; first RX_SKEW samples discarded, then
//   spi_mosi stored MSB-first into shadow byte cap_idx/8, bit 7-(cap_idx%8).
//  GAP: cs_n high CS_GAP cycles, done cleared after 1 cycle; then IDLE, cmd_ready=1.
//   cmd_valid during SHIFT/GAP ignored (held by requester). Back-to-back frames
//   therefore separated by exactly CS_GAP cycles of cs_n high.
//  cmd_len > MAX_BYTES-1: clamped to MAX_BYTES-1.
//  Counter widths sized for MAX_BYTES*8+RX_SKEW; no wrap within a frame.
// CONFIGURATION
//  SPI_HOST_BYTE_STROBE_EN defined: extra outputs rx_byte[7:0], rx_byte_valid; one-cycle
//   pulse on posedge after each completed received byte (after skew), in order.
//  Undefined: ports absent; only whole-frame rx_data/done reporting.
// STRUCTURE
//  spi_host_pkg: state enum {IDLE,SHIFT,GAP}, BYTE_W=8, default SPI constants.
//  Sub-module spi_host_capture: negedge shift/skew-discard register, cs_n-gated,
//   exporting shadow payload and byte-complete flag to posedge FSM.
// TESTING
//  1: cmd_len=0, tx=0xA5, peripheral returns 0x3C -> miso 1,0,1,0,0,1,0,1; 9 cycles
//     cs_n low; done 1 cycle; rx_data[7:0]=0x3C.
//  2: cmd_len=1, tx=0x5681 -> 0x81 then 0x56 on miso; 17 cycles cs_n low; rx both bytes.
//  3: cmd_valid held high -> frames separated by exactly CS_GAP=2 cs_n-high cycles.
//  4: rst_n low mid-SHIFT bit 4 -> cs_n=1, miso=0, no done, cmd_ready=1 after release.
//  5: cmd_len=3 (MAX) 0xDEADBEEF loopback via bridge -> rx echo matches, skew honoured.
//  6: SPI_HOST_BYTE_STROBE_EN, 2-byte frame -> two rx_byte_valid pulses 8 cycles apart.

Source files
------------

// File: rtl/spi_host_pkg.sv
// spi_host_pkg
//   Shared types and constants for the SPI host transfer engine.
//   - spi_host_state_e : engine FSM states (IDLE, SHIFT, GAP)
//   - BYTE_W           : bits per payload byte
//   - DEF_*            : default engine parameters
//   - clamp_len/idx_w  : small elaboration/run-time helpers
package spi_host_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEF_MAX_BYTES = 4;
    localparam int DEF_RX_SKEW   = 1;
    localparam int DEF_CS_GAP    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } spi_host_state_e;

    // Limit a requested byte count (minus one) to the largest the engine holds.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_host_if.sv
// spi_host_if
//   Request/response bundle between the register-access sequencer (master)
//   and the SPI host engine (slave).
//   Handshake: a frame request is accepted on the sclk posedge where
//   cmd_valid and cmd_ready are both high; cmd_len/tx_data must be stable
//   while cmd_valid is high. done pulses for one cycle with rx_data valid
//   from the same posedge. busy covers accept through end of the cs_n gap.
//   dbg_state mirrors the engine FSM state for observation.
interface spi_host_if #(
    parameter int MAX_BYTES = spi_host_pkg::DEF_MAX_BYTES
);
    import spi_host_pkg::*;

    localparam int LEN_W  = idx_w(MAX_BYTES);
    localparam int DATA_W = BYTE_W * MAX_BYTES;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [LEN_W-1:0]        cmd_len;
    logic [DATA_W-1:0]       tx_data;
    logic [DATA_W-1:0]       rx_data;
    logic                    done;
    logic                    busy;
    spi_host_state_e         dbg_state;

    modport master (
        output cmd_valid, cmd_len, tx_data,
        input  cmd_ready, rx_data, done, busy, dbg_state
    );

    modport slave (
        input  cmd_valid, cmd_len, tx_data,
        output cmd_ready, rx_data, done, busy, dbg_state
    );

endinterface

// File: rtl/spi_host_capture.sv
// spi_host_capture
//   Negedge receive path. While cs_n is low, every falling sclk edge samples
//   mosi; the first RX_SKEW samples are dropped (peripheral lags one sclk),
//   the rest fill the shadow payload MSB-first, byte 0 first. With cs_n high
//   the counter and shadow are cleared, ready for the next frame.
//   Ports: sclk, rst_n (async, active low), cs_n, mosi in;
//          shadow (payload), byte_done (one sclk period after each byte),
//          byte_idx (index of the byte just completed) out.
module spi_host_capture
    import spi_host_pkg::*;
#(
    parameter int MAX_BYTES = DEF_MAX_BYTES,
    parameter int RX_SKEW   = DEF_RX_SKEW
) (
    input  logic                          sclk,
    input  logic                          rst_n,
    input  logic                          cs_n,
    input  logic                          mosi,
    output logic [BYTE_W*MAX_BYTES-1:0]   shadow,
    output logic                          byte_done,
    output logic [idx_w(MAX_BYTES)-1:0]   byte_idx
);
    localparam int DATA_W = BYTE_W * MAX_BYTES;
    localparam int CNT_W  = $clog2(DATA_W + RX_SKEW + 1);
    localparam int TX_IW  = idx_w(DATA_W);
    localparam int BI_W   = idx_w(MAX_BYTES);

    logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic              byte_done_q, byte_done_d;
    logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]  cap_idx;

    always_comb begin
        cap_cnt_d   = cap_cnt_q;
        shadow_d    = shadow_q;
        byte_done_d = 1'b0;
        byte_idx_d  = byte_idx_q;
        cap_idx     = cap_cnt_q - CNT_W'(RX_SKEW);
        if (cs_n) begin
            cap_cnt_d = '0;
            shadow_d  = '0;
        end else begin
            cap_cnt_d = cap_cnt_q + CNT_W'(1);
            if (cap_cnt_q >= CNT_W'(RX_SKEW) && cap_idx < CNT_W'(DATA_W)) begin
                // XOR with 7 maps sequential bit k to byte k/8, bit 7-(k%8).
                shadow_d[cap_idx[TX_IW-1:0] ^ TX_IW'(7)] = mosi;
                if (&cap_idx[2:0]) begin
                    byte_done_d = 1'b1;
                    byte_idx_d  = cap_idx[BI_W+2:3];
                end
            end
        end
    end

    always_ff @(negedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cap_cnt_q   <= '0;
            shadow_q    <= '0;
            byte_done_q <= 1'b0;
            byte_idx_q  <= '0;
        end else begin
            cap_cnt_q   <= cap_cnt_d;
            shadow_q    <= shadow_d;
            byte_done_q <= byte_done_d;
            byte_idx_q  <= byte_idx_d;
        end
    end

    assign shadow    = shadow_q;
    assign byte_done = byte_done_q;
    assign byte_idx  = byte_idx_q;

endmodule

// File: rtl/spi_host_engine.sv
// spi_host_engine
//   SPI host transfer engine toward the PWM peripheral's SPI bridge.
//   Posedge FSM launches payload bits on spi_miso (byte 0 first, MSB first)
//   with spi_cs_n low for 8*(cmd_len+1)+RX_SKEW cycles, then holds cs_n high
//   for CS_GAP cycles before the next frame can start. Returned bits are
//   captured on negedge by spi_host_capture.
//   Ports: sclk, rst_n (async, active low); host (spi_host_if.slave:
//          cmd_valid/cmd_ready/cmd_len/tx_data/rx_data/done/busy/dbg_state);
//          spi_cs_n, spi_miso out; spi_mosi in.
//   Build option SPI_HOST_BYTE_STROBE_EN: adds rx_byte/rx_byte_valid, a
//   one-cycle strobe per received byte, in order.
module spi_host_engine
    import spi_host_pkg::*;
#(
    parameter int MAX_BYTES = DEF_MAX_BYTES,
    parameter int RX_SKEW   = DEF_RX_SKEW,
    parameter int CS_GAP    = DEF_CS_GAP
) (
    input  logic             sclk,
    input  logic             rst_n,
    spi_host_if.slave        host,
    output logic             spi_cs_n,
    output logic             spi_miso,
    input  logic             spi_mosi
`ifdef SPI_HOST_BYTE_STROBE_EN
    ,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              rx_byte_valid
`endif
);
    localparam int DATA_W = BYTE_W * MAX_BYTES;
    localparam int LEN_W  = idx_w(MAX_BYTES);
    localparam int CNT_W  = $clog2(DATA_W + RX_SKEW + 1);
    localparam int TX_IW  = idx_w(DATA_W);
    localparam int GAP_W  = $clog2(CS_GAP + 1);
    localparam int BI_W   = idx_w(MAX_BYTES);
    localparam int GAP_LAST = (CS_GAP > 1) ? CS_GAP - 2 : 0;

    spi_host_state_e   state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              done_q, done_d;
    logic              cs_n_q, cs_n_d;
    logic              miso_q, miso_d;

    logic [CNT_W-1:0]  n_bits;
    logic [CNT_W-1:0]  bit_nxt;
    logic [DATA_W-1:0] shadow;
    logic              byte_done;
    logic [BI_W-1:0]   byte_idx;

    spi_host_capture #(
        .MAX_BYTES (MAX_BYTES),
        .RX_SKEW   (RX_SKEW)
    ) u_capture (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .cs_n      (cs_n_q),
        .mosi      (spi_mosi),
        .shadow    (shadow),
        .byte_done (byte_done),
        .byte_idx  (byte_idx)
    );

    assign n_bits  = (CNT_W'(len_q) + CNT_W'(1)) << 3;
    assign bit_nxt = bit_cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        len_d     = len_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        done_d    = 1'b0;
        cs_n_d    = cs_n_q;
        miso_d    = miso_q;
        case (state_q)
            IDLE: begin
                if (host.cmd_valid) begin
                    len_d     = LEN_W'(clamp_len(32'(host.cmd_len), MAX_BYTES - 1));
                    tx_d      = host.tx_data;
                    cs_n_d    = 1'b0;
                    miso_d    = host.tx_data[BYTE_W-1];
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                bit_cnt_d = bit_nxt;
                if (bit_nxt < n_bits) begin
                    miso_d = tx_q[bit_nxt[TX_IW-1:0] ^ TX_IW'(7)];
                end else begin
                    miso_d = 1'b0;
                end
                // Last cycle covers the skewed final bit returning from the peripheral.
                if (bit_cnt_q == n_bits + CNT_W'(RX_SKEW) - CNT_W'(1)) begin
                    cs_n_d    = 1'b1;
                    rx_d      = shadow;
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = (CS_GAP > 1) ? GAP : IDLE;
                end
            end
            GAP: begin
                // The IDLE cycle before the next accept is the final gap cycle.
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            len_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            done_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            len_q     <= len_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            done_q    <= done_d;
            cs_n_q    <= cs_n_d;
            miso_q    <= miso_d;
        end
    end

    assign host.cmd_ready = (state_q == IDLE);
    assign host.busy      = (state_q != IDLE);
    assign host.done      = done_q;
    assign host.rx_data   = rx_q;
    assign host.dbg_state = state_q;
    assign spi_cs_n       = cs_n_q;
    assign spi_miso       = miso_q;

`ifdef SPI_HOST_BYTE_STROBE_EN
    logic [BYTE_W-1:0] rx_byte_q, rx_byte_d;
    logic              rx_byte_valid_q, rx_byte_valid_d;

    // byte_done is held a full sclk period by the negedge side, so exactly
    // one posedge sees it per byte.
    always_comb begin
        rx_byte_valid_d = byte_done;
        rx_byte_d       = rx_byte_q;
        if (byte_done) begin
            rx_byte_d = shadow[{byte_idx, 3'b000} +: BYTE_W];
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_byte_q       <= '0;
            rx_byte_valid_q <= 1'b0;
        end else begin
            rx_byte_q       <= rx_byte_d;
            rx_byte_valid_q <= rx_byte_valid_d;
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = rx_byte_valid_q;
`else
    logic unused_byte_strobe;
    assign unused_byte_strobe = ^{byte_done, byte_idx};
`endif

endmodule

// File: tb/tb_spi_host_engine.sv
module tb_spi_host_engine;
    import spi_host_pkg::*;

    localparam int MB     = 4;
    localparam int SK     = 1;
    localparam int CS_GAP_T = 2;
    localparam int W      = 72;   // {low_cycles[7:0], tx_seen[31:0], rx[31:0]}

    // ---------------- clock / reset ----------------
    logic sclk  = 1'b0;
    logic rst_n = 1'b0;
    always #5 sclk = ~sclk;

    logic spi_cs_n, spi_miso;
    logic spi_mosi = 1'b0;

    spi_host_if #(.MAX_BYTES(MB)) bus ();

`ifdef SPI_HOST_BYTE_STROBE_EN
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
`endif

    spi_host_engine #(.MAX_BYTES(MB), .RX_SKEW(SK), .CS_GAP(CS_GAP_T)) dut (
        .sclk          (sclk),
        .rst_n         (rst_n),
        .host          (bus.slave),
        .spi_cs_n      (spi_cs_n),
        .spi_miso      (spi_miso),
        .spi_mosi      (spi_mosi)
`ifdef SPI_HOST_BYTE_STROBE_EN
        ,
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid)
`endif
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   exp_b_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- peripheral model ----------------
    // Launches on posedge while cs_n low, so its output lags one sclk.
    logic        loop_mode = 1'b0;
    logic [31:0] resp = '0;
    int          pcnt = 0;
    always @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            spi_mosi <= 1'b0;
            pcnt     <= 0;
        end else if (!spi_cs_n) begin
            if (loop_mode) spi_mosi <= spi_miso;
            else           spi_mosi <= (pcnt < 32) ? resp[pcnt ^ 7] : 1'b0;
            pcnt <= pcnt + 1;
        end else begin
            spi_mosi <= 1'b0;
            pcnt     <= 0;
        end
    end

    // ---------------- monitor ----------------
    int          lowcnt = 0, hicnt = 0, done_cnt = 0, start_cnt = 0;
    logic        cs_prev = 1'b1, done_prev = 1'b0;
    logic        gap_check = 1'b0, gap_armed = 1'b0;
    logic [31:0] seen = '0;
    logic [W-1:0] e;
`ifdef SPI_HOST_BYTE_STROBE_EN
    int cyc = 0, last_cyc = 0, bif = 0;
`endif

    always @(negedge sclk) begin
        if (rst_n) begin
            if (!spi_cs_n) begin
                if (cs_prev) begin
                    if (gap_armed) check("cs_gap_cycles", 64'(hicnt), 64'(CS_GAP_T));
                    gap_armed = 1'b0;
                    lowcnt    = 0;
                    seen      = '0;
                    start_cnt++;
                end
                if (lowcnt < 32) seen[lowcnt ^ 7] = spi_miso;
                lowcnt++;
            end else begin
                hicnt++;
            end
`ifdef SPI_HOST_BYTE_STROBE_EN
            cyc++;
            if (rx_byte_valid) begin
                check("byte_sb_depth", 64'(exp_b_q.size() > 0), 64'(1));
                if (exp_b_q.size() > 0) check("rx_byte", 64'(rx_byte), 64'(exp_b_q.pop_front()));
                if (bif > 0) check("byte_spacing", 64'(cyc - last_cyc), 64'(8));
                last_cyc = cyc;
                bif++;
            end
`endif
            if (bus.done) begin
                check("done_pulse_width", 64'(done_prev), 64'(0));
                done_cnt++;
                check("sb_depth", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rx_data", 64'(bus.rx_data), 64'(e[31:0]));
                    check("miso_stream", 64'(seen), 64'(e[63:32]));
                    check("cs_low_cycles", 64'(lowcnt), 64'(e[71:64]));
                end
                if (gap_check) gap_armed = 1'b1;
                hicnt = 1;
`ifdef SPI_HOST_BYTE_STROBE_EN
                bif = 0;
`endif
            end
            cs_prev   = spi_cs_n;
            done_prev = bus.done;
        end else begin
            cs_prev   = 1'b1;
            done_prev = 1'b0;
            gap_armed = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input int len, input logic [31:0] tx, input logic [31:0] rsp, input bit loop);
        logic [31:0] mask;
        logic [31:0] rx;
        mask = '0;
        for (int b = 0; b <= len; b++) mask[b*8 +: 8] = 8'hFF;
        rx = loop ? (tx & mask) : (rsp & mask);
        exp_q.push_back({8'(8 * (len + 1) + SK), tx & mask, rx});
        for (int b = 0; b <= len; b++) exp_b_q.push_back(rx[b*8 +: 8]);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100; i++) begin
            @(negedge sclk);
            if (bus.cmd_ready) break;
        end
        check("ready_timeout", 64'(bus.cmd_ready), 64'(1));
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 200; i++) begin
            if (done_cnt >= target) break;
            @(posedge sclk);
        end
        check("done_timeout", 64'(done_cnt >= target), 64'(1));
    endtask

    task automatic send(input int len, input logic [31:0] tx, input logic [31:0] rsp, input bit loop);
        int t;
        wait_ready();
        push_exp(len, tx, rsp, loop);
        resp          = rsp;
        loop_mode     = loop;
        bus.cmd_len   = 2'(len);
        bus.tx_data   = tx;
        bus.cmd_valid = 1'b1;
        t = done_cnt + 1;
        @(posedge sclk);
        #1 bus.cmd_valid = 1'b0;
        wait_done(t);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s0, d0;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.tx_data   = '0;

        // Reset values
        repeat (3) @(negedge sclk);
        check("rst_cs_n", 64'(spi_cs_n), 64'(1));
        check("rst_miso", 64'(spi_miso), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_ready", 64'(bus.cmd_ready), 64'(1));
        check("rst_rx_data", 64'(bus.rx_data), 64'(0));
        check("rst_state", 64'(bus.dbg_state), 64'(IDLE));
        rst_n = 1'b1;
        @(negedge sclk);

        // 1: single byte
        send(0, 32'h0000_00A5, 32'h0000_003C, 1'b0);
        // 2: two bytes, byte0 first
        send(1, 32'h0000_5681, 32'h0000_9AC3, 1'b0);
        // 3-byte frame with response pattern
        send(2, 32'h00C0_FFEE, 32'h0012_3456, 1'b0);
        // 5: max length, loopback through bridge
        send(3, 32'hDEAD_BEEF, 32'h0, 1'b1);

        // 3: cmd_valid held -> back-to-back frames with exact cs_n gap
        wait_ready();
        push_exp(0, 32'h77, 32'h11, 1'b0);
        push_exp(0, 32'h77, 32'h11, 1'b0);
        resp = 32'h11; loop_mode = 1'b0;
        s0 = start_cnt; d0 = done_cnt;
        gap_check     = 1'b1;
        bus.cmd_len   = 2'd0;
        bus.tx_data   = 32'h77;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge sclk);
            if (start_cnt >= s0 + 2) break;
        end
        bus.cmd_valid = 1'b0;
        check("held_start_timeout", 64'(start_cnt >= s0 + 2), 64'(1));
        wait_done(d0 + 2);
        gap_check = 1'b0;
        gap_armed = 1'b0;

        // 4: reset during SHIFT at bit 4
        wait_ready();
        d0 = done_cnt;
        resp = 32'h0; loop_mode = 1'b0;
        bus.cmd_len   = 2'd0;
        bus.tx_data   = 32'h0F;
        bus.cmd_valid = 1'b1;
        @(posedge sclk);
        #1 bus.cmd_valid = 1'b0;
        repeat (4) @(posedge sclk);
        #1;
        check("pre_rst_cs_n", 64'(spi_cs_n), 64'(0));
        check("pre_rst_miso_bit4", 64'(spi_miso), 64'(1));
        rst_n = 1'b0;
        #1;
        check("abort_cs_n", 64'(spi_cs_n), 64'(1));
        check("abort_miso", 64'(spi_miso), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_rx_data", 64'(bus.rx_data), 64'(0));
        repeat (3) @(negedge sclk);
        rst_n = 1'b1;
        @(negedge sclk);
        check("post_rst_ready", 64'(bus.cmd_ready), 64'(1));
        check("post_rst_state", 64'(bus.dbg_state), 64'(IDLE));
        repeat (20) @(negedge sclk);
        check("abort_no_done", 64'(done_cnt), 64'(d0));

        // Recovery frame after abort
        send(1, 32'h0000_1234, 32'h0000_A55A, 1'b0);

        repeat (5) @(negedge sclk);
        check("sb_drained", 64'(exp_q.size()), 64'(0));
`ifdef SPI_HOST_BYTE_STROBE_EN
        check("byte_sb_drained", 64'(exp_b_q.size()), 64'(0));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
